// File: rtl/mem_port_sequencer_pkg.sv
// Shared encodings for the memory-port sequencer: request lengths, FSM states
// and the default IO region tag.
package mem_port_sequencer_pkg;

    localparam logic [2:0] LEN_BYTE = 3'd0;
    localparam logic [2:0] LEN_HALF = 3'd1;
    localparam logic [2:0] LEN_WORD = 3'd2;

    localparam logic [1:0] IO_BASE_HI_DEF = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } seq_state_t;

    // Lengths above LEN_WORD are treated as a full word.
    function automatic logic [2:0] len_to_n(input logic [2:0] len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_sequencer_if.sv
// Request/response handshake between the cache arbiter and the sequencer.
interface mem_port_sequencer_if;

    logic        waiting;
    logic        wr;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] value;
    logic        ready;
    logic [31:0] result;

    modport master (output waiting, wr, len, addr, value, input ready, result);
    modport slave  (input waiting, wr, len, addr, value, output ready, result);

endinterface

// File: rtl/mem_port_sequencer.sv
// Serialises one byte/half/word cache request onto the byte-wide RAM/IO bus
// and returns assembled read data with a one-cycle ready pulse.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// ST_IDLE  | waiting for an unblocked request; memory bus parked at 0
// ST_READ  | issuing addresses and capturing bytes two edges behind
// ST_WRITE | driving one byte per cycle; completes even after a flush
module mem_port_sequencer
    import mem_port_sequencer_pkg::*;
#(
    parameter logic [1:0] IO_BASE_HI = IO_BASE_HI_DEF
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        RoB_clear,
    mem_port_sequencer_if.slave         req,
    input  logic [7:0]                  mem_din,
    output logic [7:0]                  mem_dout,
    output logic [31:0]                 mem_a,
    output logic                        mem_wr,
    input  logic                        io_buffer_full
);

    seq_state_t  state_q, state_d;
    logic [2:0]  cnt_iss_q, cnt_iss_d;
    logic [2:0]  cnt_cap_q, cnt_cap_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic        flushed_q, flushed_d;
    logic        ready_q, ready_d;
    logic [31:0] result_q, result_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;

    logic        blocked;
    logic [1:0]  cap_idx;

    assign blocked = req.wr && (req.addr[17:16] == IO_BASE_HI) && io_buffer_full;
    // cnt_cap counts READ edges since accept; byte k lands when it reaches k+1
    assign cap_idx = cnt_cap_q[1:0] - 2'd1;

    always_comb begin
        state_d    = state_q;
        cnt_iss_d  = cnt_iss_q;
        cnt_cap_d  = cnt_cap_q;
        nbytes_d   = nbytes_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        flushed_d  = flushed_q;
        ready_d    = 1'b0;
        result_d   = result_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (RoB_clear) begin
                    mem_wr_d = 1'b0;
                    mem_a_d  = '0;
                end else if (req.waiting && !ready_q && !blocked) begin
                    base_d    = req.addr;
                    wdata_d   = req.value;
                    nbytes_d  = len_to_n(req.len);
                    flushed_d = 1'b0;
                    rbuf_d    = '0;
                    cnt_iss_d = 3'd1;
                    cnt_cap_d = 3'd0;
                    mem_a_d   = req.addr;
                    if (req.wr) begin
                        state_d    = ST_WRITE;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = req.value[7:0];
                    end else begin
                        state_d  = ST_READ;
                        mem_wr_d = 1'b0;
                    end
                end
            end
            ST_READ: begin
                if (RoB_clear) begin
                    state_d   = ST_IDLE;
                    mem_a_d   = '0;
                    mem_wr_d  = 1'b0;
                    cnt_iss_d = 3'd0;
                    cnt_cap_d = 3'd0;
                end else begin
                    if (cnt_iss_q < nbytes_q) begin
                        mem_a_d   = base_q + {29'd0, cnt_iss_q};
                        cnt_iss_d = cnt_iss_q + 3'd1;
                    end
                    if (cnt_cap_q != 3'd0)
                        rbuf_d[{cap_idx, 3'b000} +: 8] = mem_din;
                    if (cnt_cap_q == nbytes_q) begin
                        state_d   = ST_IDLE;
                        ready_d   = 1'b1;
                        result_d  = rbuf_d;
                        mem_a_d   = '0;
                        cnt_iss_d = 3'd0;
                        cnt_cap_d = 3'd0;
                    end else begin
                        cnt_cap_d = cnt_cap_q + 3'd1;
                    end
                end
            end
            ST_WRITE: begin
                flushed_d = flushed_q | RoB_clear;
                if (cnt_iss_q == nbytes_q) begin
                    state_d   = ST_IDLE;
                    ready_d   = !(flushed_q || RoB_clear);
                    mem_wr_d  = 1'b0;
                    mem_a_d   = '0;
                    cnt_iss_d = 3'd0;
                end else begin
                    mem_a_d    = base_q + {29'd0, cnt_iss_q};
                    mem_dout_d = wdata_q[{cnt_iss_q[1:0], 3'b000} +: 8];
                    cnt_iss_d  = cnt_iss_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // rdy_in low freezes everything, including the pulse in flight
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            cnt_iss_q  <= '0;
            cnt_cap_q  <= '0;
            nbytes_q   <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            flushed_q  <= 1'b0;
            ready_q    <= 1'b0;
            result_q   <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_iss_q  <= cnt_iss_d;
            cnt_cap_q  <= cnt_cap_d;
            nbytes_q   <= nbytes_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            flushed_q  <= flushed_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    assign req.ready  = ready_q;
    assign req.result = result_q;
    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    assign mem_wr     = mem_wr_q;

endmodule

// File: doc/mem_port_sequencer.md
# mem_port_sequencer

Responder side of the cache-to-memory request protocol. Accepts one byte/half/word read or write request from the cache arbiter and serialises it onto the single-byte RAM/IO bus. Assembles read bytes into a 32-bit result and returns it with a one-cycle `ready` pulse. Sits between the cache arbiter and the top-level `mem_din`/`mem_dout`/`mem_a`/`mem_wr` pins.

## Interface
- `IO_BASE_HI`, default `2'b11`: value of `addr[17:16]` that marks the IO region.
- `clk_in` in 1: system clock; the only clock.
- `rst_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: global enable. While low, all state and outputs hold.
- `RoB_clear` in 1: pipeline flush.
- `waiting` in 1: request valid, held high by the requester until it sees `ready`.
- `wr` in 1: request is a write.
- `len` in 3: 0 = byte, 1 = half, 2 = word; values 3..7 are treated as word.
- `addr` in 32: base address; byte k goes to `addr+k`.
- `value` in 32: write data, little-endian.
- `ready` out 1: one-cycle completion pulse.
- `result` out 32: zero-extended read data; valid while `ready` is high.
- `mem_din` in 8: RAM/IO read byte.
- `mem_dout` out 8: write byte.
- `mem_a` out 32: byte address (bits 17:0 used).
- `mem_wr` out 1: 1 = write.
- `io_buffer_full` in 1: the IO write sink cannot accept a byte.

## Operation
- States: IDLE, READ, WRITE. N = 1, 2 or 4 according to `len`.
- **IDLE, accept condition:** at an edge where `waiting=1`, `ready=0` and the request is not blocked, the block latches `wr/len/addr/value`.
  - A request is blocked when `wr=1`, `addr[17:16]==IO_BASE_HI` and `io_buffer_full=1`; IDLE holds until it clears.
- **Accepting a read:** go to READ and drive `mem_a=addr`, `mem_wr=0`.
- **Accepting a write:** go to WRITE and drive `mem_a=addr`, `mem_wr=1`, `mem_dout=value[7:0]`.
- **READ:**
  - Issue counter presents `addr+1 .. addr+N-1` on successive edges.
  - Capture counter stores `mem_din` into `result[8k+7:8k]` at edge k+2 after accept.
  - Bytes not read are 0.
  - After the last capture: `ready=1`, go to IDLE, `mem_a=0`.
- **WRITE:**
  - Byte k is driven (`mem_a=addr+k`, `mem_dout=value[8k+7:8k]`) in the cycle after edge k.
  - After N bytes: `mem_wr=0`, `mem_a=0`, `ready=1`, go to IDLE.
- `ready` is high for exactly one cycle. No request is accepted in the cycle `ready` is high. A still-high `waiting` in the next cycle is a new request.
- **`RoB_clear=1`:**
  - IDLE or READ: go to IDLE immediately, suppress `ready`, `mem_wr=0`, `mem_a=0`.
  - WRITE in progress: the remaining bytes complete, but `ready` is suppressed.
  - No accept occurs on a clear edge.
- **`rdy_in=0`:** counters, state, `result`, `ready` and memory outputs all hold. The memory is frozen by the same signal. Overrides everything except reset.
- **Reset (low):** state IDLE; `ready=0`, `result=0`, `mem_a=0`, `mem_dout=0`, `mem_wr=0`, counters 0. Reset mid-transaction discards it.

## Timing
- RAM read latency: the address registered at edge e gives `mem_din` valid after edge e+1.
- Accept edge = E0.
- Reads: `ready` is high in the cycle after edge E0+N+1.
  - Byte: 2 cycles. Half: 3 cycles. Word: 5 cycles.
- Writes: `ready` is high in the cycle after edge E0+N.
  - Byte: 1 cycle. Word: 4 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Address arithmetic is 32-bit modulo 2^32; `addr+k` wraps at 0xFFFFFFFF.

## Structure
- Shared package holds:
  - `len` encodings (LEN_BYTE=0, LEN_HALF=1, LEN_WORD=2);
  - the state enum;
  - the IO region constant.
- Single module. The byte-count decode and the two small counters are local, so no sub-module is natural.

## Test plan
- **Word read:** RAM[0x100..0x103]=11,22,33,44; read word 0x100 -> `ready` after 5 cycles, `result=0x44332211`, `mem_wr` never high.
- **Half write:** write half 0x200, `value=0xDEADBEEF` -> RAM[0x200]=EF, RAM[0x201]=BE, `ready` after 2 cycles, RAM[0x202] unchanged.
- **Back-to-back requests:** `waiting` held across `ready` with a new address -> new accept exactly one cycle after `ready`, no gap lost, first `result` unchanged until the second `ready`.
- **IO write backpressure:** byte write 0x30000 with `io_buffer_full=1` for 3 cycles -> `mem_wr` stays 0 for those cycles, then byte written, `ready` one cycle later.
- **Flush:**
  - `RoB_clear` on the 2nd cycle of a word read -> IDLE next cycle, no `ready`.
  - Same during a word write -> all 4 bytes written, no `ready`.
- **Stall and async reset:**
  - `rdy_in` low 3 cycles mid word read -> latency extended by exactly 3, correct `result`.
  - Async `rst_in` low mid-cycle -> all outputs 0 immediately.
